// File: rtl/mem_arb_pkg.sv
// Shared types, widths and parameter checks for the CPU/DMA memory bus arbiter.
package mem_arb_pkg;

  localparam int unsigned DMA_ADDR_W = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned STALL_W    = 16;

  typedef enum logic [0:0] {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  // One bus master's view of a memory cycle
  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic                  we;
  } mem_req_t;

  function automatic bit param_in_range(input int unsigned v);
    return (v >= 1) && (v <= 255);
  endfunction

endpackage

// File: rtl/bus_mux.sv
// Combinational owner select of the memory address, write data and write enable.
module bus_mux
  import mem_arb_pkg::*;
(
  input  logic     owner_dma_i,
  input  mem_req_t cpu_req_i,
  input  mem_req_t dma_req_i,
  output mem_req_t mem_req_c_o
);

  always_comb begin
    mem_req_c_o = cpu_req_i;
    if (owner_dma_i) mem_req_c_o = dma_req_i;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA memory bus arbiter: stalls the CPU through RDY, bounds DMA bursts, and
// guarantees CPU slots between bursts. `ARB_STALL_CNT_EN adds a stall_cnt debug counter.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CPU_SLOTS = 1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DMA_ADDR_W-1:0] cpu_AD,
  input  logic [DATA_W-1:0]     cpu_DO,
  input  logic                  cpu_WE,
  output logic [DATA_W-1:0]     cpu_DI,
  output logic                  RDY,
  input  logic                  dma_req,
  input  logic [DMA_ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wdata,
  input  logic                  dma_we,
  output logic                  dma_gnt,
  output logic                  dma_ack,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic [DMA_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0]    stall_cnt
`endif
);

  if (!param_in_range(MAX_BURST)) begin : g_bad_max_burst
    $error("mem_bus_arbiter: MAX_BURST must be within 1..255");
  end
  if (!param_in_range(CPU_SLOTS)) begin : g_bad_cpu_slots
    $error("mem_bus_arbiter: CPU_SLOTS must be within 1..255");
  end

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(CPU_SLOTS - 1);

  arb_state_e       state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= S_CPU;
      rdy_q       <= 1'b1;
      burst_cnt_q <= '0;
      cool_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      burst_cnt_q <= burst_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    burst_cnt_d = burst_cnt_q;
    cool_cnt_d  = cool_cnt_q;
    case (state_q)
      S_CPU: begin
        if (cool_cnt_q != '0) begin
          cool_cnt_d = cool_cnt_q - CNT_W'(1);
        end else if (dma_req) begin
          state_d     = S_DMA;
          rdy_d       = 1'b0;
          burst_cnt_d = '0;
        end
      end
      S_DMA: begin
        // Release on idle request or after the last allowed beat of the burst
        if (!dma_req || (burst_cnt_q == LAST_BEAT)) begin
          state_d    = S_CPU;
          rdy_d      = 1'b1;
          cool_cnt_d = COOL_INIT;
        end else begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_CPU;
    endcase
  end

  mem_req_t cpu_side, dma_side, mem_side;

  assign cpu_side = '{addr: cpu_AD, wdata: cpu_DO, we: cpu_WE};
  assign dma_side = '{addr: dma_addr, wdata: dma_wdata, we: dma_we & dma_req};

  bus_mux u_bus_mux (
    .owner_dma_i (state_q == S_DMA),
    .cpu_req_i   (cpu_side),
    .dma_req_i   (dma_side),
    .mem_req_c_o (mem_side)
  );

  assign mem_addr  = mem_side.addr;
  assign mem_wdata = mem_side.wdata;
  assign mem_we    = mem_side.we;
  assign RDY       = rdy_q;
  assign dma_gnt   = (state_q == S_DMA);
  assign dma_ack   = (state_q == S_DMA) & dma_req;
  assign cpu_DI    = mem_rdata;
  assign dma_rdata = mem_rdata;

`ifdef ARB_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Saturating count of cycles the CPU sees RDY low
  always_comb begin
    stall_d = stall_q;
    if (!rdy_q && (stall_q != '1)) stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (RST) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a transfer-level model of bus ownership.
module tb_mem_bus_arbiter;

  localparam int unsigned MAXB  = 4;
  localparam int unsigned SLOTS = 1;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] cpu_AD;
  logic [7:0]  cpu_DO;
  logic        cpu_WE;
  logic [7:0]  cpu_DI;
  logic        RDY;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        dma_gnt;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_BURST(MAXB), .CPU_SLOTS(SLOTS)) dut (
    .clk       (clk),
    .RST       (RST),
    .cpu_AD    (cpu_AD),
    .cpu_DO    (cpu_DO),
    .cpu_WE    (cpu_WE),
    .cpu_DI    (cpu_DI),
    .RDY       (RDY),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_we    (dma_we),
    .dma_gnt   (dma_gnt),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
`ifdef ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [7:0] memf(input logic [15:0] a);
    if (a == 16'h0200) return 8'hEA;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Combinational memory
  assign mem_rdata = memf(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Ownership model: DMA owns the bus for at most MAXB transfers, and the CPU
  // must see SLOTS RDY-high cycles after a burst before DMA may own it again.
  bit          m_own;
  int          m_xfers;
  int          m_cpu_run;
  int unsigned m_stall;

  always @(posedge clk) begin
    if (RST) begin
      m_own     = 1'b0;
      m_xfers   = 0;
      m_cpu_run = SLOTS;
      m_stall   = 0;
    end else begin
      if (m_own && m_stall != 32'hFFFF) m_stall = m_stall + 1;
      if (m_own) begin
        if (!dma_req || (m_xfers + 1 == MAXB)) begin
          m_own     = 1'b0;
          m_cpu_run = 0;
        end else begin
          m_xfers = m_xfers + 1;
        end
      end else if ((m_cpu_run + 1 >= SLOTS) && dma_req) begin
        m_own   = 1'b1;
        m_xfers = 0;
      end else if (m_cpu_run < 1000) begin
        m_cpu_run = m_cpu_run + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] ea;
      ea = m_own ? dma_addr : cpu_AD;
      chk("rdy",       32'(RDY),       32'(!m_own));
      chk("gnt",       32'(dma_gnt),   32'(m_own));
      chk("ack",       32'(dma_ack),   32'(m_own & dma_req));
      chk("mem_addr",  32'(mem_addr),  32'(ea));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_own ? dma_wdata : cpu_DO));
      chk("mem_we",    32'(mem_we),    32'(m_own ? (dma_we & dma_req) : cpu_WE));
      chk("cpu_di",    32'(cpu_DI),    32'(memf(ea)));
      chk("dma_rdata", 32'(dma_rdata), 32'(memf(ea)));
`ifdef ARB_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), m_stall);
`endif
    end
  end

  int wr6000     = 0;
  int wr6000_low = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1 && mem_addr == 16'h6000) begin
      wr6000++;
      if (RDY !== 1'b1) wr6000_low++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #2;
  endtask

  logic [10:0] burst_pat;

  initial begin
    RST = 1'b1; dma_req = 1'b1; cpu_AD = 16'h1234; cpu_DO = 8'h00; cpu_WE = 1'b0;
    dma_addr = 16'h0400; dma_wdata = 8'h11; dma_we = 1'b0;
    cyc();
    chk_en = 1'b1;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rst_rdy", 32'(RDY), 32'd1);
      chk("rst_gnt", 32'(dma_gnt), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'h1234);
      cyc();
    end
    RST = 1'b0;
    mid(); chk("post_rst_ack0", 32'(dma_ack), 32'd0);
    cyc();
    mid(); chk("post_rst_ack1", 32'(dma_ack), 32'd1);
    cyc();
    dma_req = 1'b0;
    mid(); chk("drop_noack", 32'(dma_ack), 32'd0);
    cyc();
    mid(); chk("drop_release", 32'(RDY), 32'd1);
    cyc();

    // Single read
    cpu_AD = 16'hFFFC; dma_addr = 16'h0200; dma_req = 1'b1;
    mid(); chk("rd_rdy_hi", 32'(RDY), 32'd1);
    cyc();
    mid();
    chk("rd_rdy_lo", 32'(RDY), 32'd0);
    chk("rd_addr", 32'(mem_addr), 32'h0200);
    chk("rd_ack", 32'(dma_ack), 32'd1);
    chk("rd_data", 32'(dma_rdata), 32'hEA);
    cyc();
    dma_req = 1'b0;
    cyc();
    mid();
    chk("rd_back_rdy", 32'(RDY), 32'd1);
    chk("rd_back_addr", 32'(mem_addr), 32'hFFFC);
    cyc();

    // Burst limit with the request held: 0 1111 0 1111 0
    burst_pat = 11'b0_1111_0_1111_0;
    dma_req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      mid();
      chk("burst_ack", 32'(dma_ack), 32'(burst_pat[10-i]));
      chk("burst_rdy", 32'(RDY), 32'(!burst_pat[10-i]));
      cyc();
    end
    dma_req = 1'b0;
    mid(); chk("burst_regrant", 32'(dma_gnt), 32'd1);
    cyc();
    cyc();

    // CPU write issued as RDY drops is frozen and performed once afterwards
    dma_req = 1'b1; dma_addr = 16'h0300; dma_we = 1'b1; dma_wdata = 8'hAA;
    cyc();
    cpu_AD = 16'h6000; cpu_DO = 8'h55; cpu_WE = 1'b1;
    mid(); chk("wp_rdy_lo", 32'(RDY), 32'd0);
    cyc();
    dma_req = 1'b0;
    begin
      int budget = 10;
      mid();
      while (RDY !== 1'b1 && budget > 0) begin
        cyc(); mid(); budget--;
      end
      chk("wp_rdy_back", 32'(RDY), 32'd1);
    end
    cyc();
    cpu_WE = 1'b0; cpu_AD = 16'h0010;
    cyc();
    chk("wp_once", 32'(wr6000), 32'd1);
    chk("wp_stalled", 32'(wr6000_low), 32'd0);

    // Reset in the middle of a burst
    dma_we = 1'b0; dma_req = 1'b1;
    cyc();
    mid(); chk("mr_ack1", 32'(dma_ack), 32'd1);
    cyc();
    RST = 1'b1;
    mid(); chk("mr_ack2", 32'(dma_ack), 32'd1);
    cyc();
    RST = 1'b0;
    mid();
    chk("mr_rdy", 32'(RDY), 32'd1);
    chk("mr_gnt", 32'(dma_gnt), 32'd0);
    chk("mr_noack", 32'(dma_ack), 32'd0);
    cyc();
    mid(); chk("mr_regrant", 32'(dma_ack), 32'd1);
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RST       = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) dma_req = ~dma_req;
      dma_addr  = 16'($urandom);
      dma_wdata = 8'($urandom);
      dma_we    = 1'($urandom);
      cpu_AD    = 16'($urandom);
      cpu_DO    = 8'($urandom);
      cpu_WE    = 1'($urandom);
      cyc();
    end

    RST = 1'b0; dma_req = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
